// File: rtl/rv32_alu_decoder_pkg.sv
// rv32_pkg: shared opcode constants, funct7 encodings and the decoded ALU
// request bundle used by the RV32I decode stage.
`timescale 1ns/1ps
package rv32_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic        we;
    logic        illegal;
  } alu_req_t;

endpackage

// File: rtl/rv32_alu_decoder_if.sv
// Valid/ready bundle between fetch/regfile read and the ALU decode stage,
// and between the decode stage and execute. The decoder uses the slave view.
`timescale 1ns/1ps
interface rv32_alu_decoder_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_rs1_data;
  logic [XLEN-1:0] in_rs2_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_a;
  logic [XLEN-1:0] out_b;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [4:0]      out_rd;
  logic            out_we;
  logic            out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, out_ready,
    output in_ready, out_valid, out_a, out_b, out_funct3, out_funct7,
           out_rd, out_we, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_funct3, out_funct7,
           out_rd, out_we, out_illegal
  );
endinterface

// File: rtl/rv32_alu_decode_comb.sv
// Pure combinational RV32I decode of OP / OP-IMM / LUI / AUIPC into an ALU
// request. Anything else, or a bad funct7, yields an all-zero illegal request.
`timescale 1ns/1ps
module rv32_alu_decode_comb
  import rv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  output alu_req_t        o_req
);

  logic [6:0]         w_opc;
  logic [2:0]         w_f3;
  logic [6:0]         w_f7;
  logic [4:0]         w_rd;
  logic signed [31:0] w_imm_i;
  logic [31:0]        w_imm_u;
  logic [31:0]        w_shamt;

  assign w_opc   = i_instr[6:0];
  assign w_f3    = i_instr[14:12];
  assign w_f7    = i_instr[31:25];
  assign w_rd    = i_instr[11:7];
  assign w_imm_i = 32'(signed'(i_instr[31:20]));
  assign w_imm_u = {i_instr[31:12], 12'b0};
  assign w_shamt = {27'b0, i_instr[24:20]};

  // Operand selection and legality check; illegal squashes the whole bundle.
  always_comb begin
    logic w_ok;
    w_ok        = 1'b0;
    o_req       = '0;
    o_req.rd    = w_rd;
    case (w_opc)
      OPC_OP: begin
        w_ok         = (w_f7 == F7_BASE) ||
                       ((w_f7 == F7_ALT) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
        o_req.a      = i_rs1;
        o_req.b      = i_rs2;
        o_req.funct3 = w_f3;
        o_req.funct7 = w_f7;
      end
      OPC_OP_IMM: begin
        o_req.a      = i_rs1;
        o_req.funct3 = w_f3;
        if (w_f3 == 3'b001) begin
          w_ok    = (w_f7 == F7_BASE);
          o_req.b = w_shamt;
        end else if (w_f3 == 3'b101) begin
          w_ok         = (w_f7 == F7_BASE) || (w_f7 == F7_ALT);
          o_req.b      = w_shamt;
          o_req.funct7 = w_f7;
        end else begin
          w_ok    = 1'b1;
          o_req.b = w_imm_i;
        end
      end
      OPC_LUI: begin
        w_ok    = 1'b1;
        o_req.b = w_imm_u;
      end
      OPC_AUIPC: begin
        w_ok    = 1'b1;
        o_req.a = i_pc;
        o_req.b = w_imm_u;
      end
      default: w_ok = 1'b0;
    endcase
    if (w_ok) begin
      o_req.we = (w_rd != 5'd0);
    end else begin
      o_req         = '0;
      o_req.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/rv32_alu_decoder.sv
// RV32I ALU decode stage: combinational decode feeding an output register
// backed by a one-entry skid register, so the stage runs at full throughput
// while in_ready stays a registered signal.
// Optional statistics counters are built when DECODE_STATS_EN is defined.
`timescale 1ns/1ps
module rv32_alu_decoder
  import rv32_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rv32_alu_decoder_if.slave    bus
`ifdef DECODE_STATS_EN
  ,
  output logic [CNT_W-1:0]     stat_issued,
  output logic [CNT_W-1:0]     stat_illegal
`endif
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  alu_req_t w_dec;
  alu_req_t r_out;
  alu_req_t r_skid;
  logic     r_out_vld;
  logic     r_skid_vld;
  logic     w_acc;
  logic     w_drain;
  logic     w_out_free;

  rv32_alu_decode_comb #(.XLEN(XLEN)) u_dec (
    .i_instr (bus.in_instr),
    .i_pc    (bus.in_pc),
    .i_rs1   (bus.in_rs1_data),
    .i_rs2   (bus.in_rs2_data),
    .o_req   (w_dec)
  );

  assign bus.in_ready = !r_skid_vld;
  assign w_acc        = bus.in_valid && !r_skid_vld;
  assign w_drain      = r_out_vld && bus.out_ready;
  assign w_out_free   = !r_out_vld || bus.out_ready;

  assign bus.out_valid   = r_out_vld;
  assign bus.out_a       = r_out.a;
  assign bus.out_b       = r_out.b;
  assign bus.out_funct3  = r_out.funct3;
  assign bus.out_funct7  = r_out.funct7;
  assign bus.out_rd      = r_out.rd;
  assign bus.out_we      = r_out.we;
  assign bus.out_illegal = r_out.illegal;

  // Output register refills from skid first (FIFO order), else from the
  // decoder; when the output is stalled an accepted input parks in skid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out      <= '0;
      r_skid     <= '0;
      r_out_vld  <= 1'b0;
      r_skid_vld <= 1'b0;
    end else if (w_out_free) begin
      if (r_skid_vld) begin
        r_out      <= r_skid;
        r_out_vld  <= 1'b1;
        r_skid_vld <= 1'b0;
      end else if (w_acc) begin
        r_out     <= w_dec;
        r_out_vld <= 1'b1;
      end else begin
        r_out_vld <= 1'b0;
      end
    end else if (w_acc) begin
      r_skid     <= w_dec;
      r_skid_vld <= 1'b1;
    end
  end

`ifdef DECODE_STATS_EN
  logic [CNT_W-1:0] r_stat_issued;
  logic [CNT_W-1:0] r_stat_illegal;

  // Saturating counts of bundles handed to execute; illegal ones count twice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_issued  <= '0;
      r_stat_illegal <= '0;
    end else if (w_drain) begin
      r_stat_issued <= sat_inc(r_stat_issued);
      if (r_out.illegal) r_stat_illegal <= sat_inc(r_stat_illegal);
    end
  end

  assign stat_issued  = r_stat_issued;
  assign stat_illegal = r_stat_illegal;
`else
  logic w_unused;
  assign w_unused = w_drain & (&sat_inc('0));
`endif

endmodule
